cordic_share_arbiter: RTL
=========================

Name: cordic_share_arbiter

Overview:
- Shares one AXI-Stream CORDIC core between NUM_REQ requesters.
- Input side: round-robin arbitration of single-beat requests onto the CORDIC input channel; the requester ID of each accepted beat is pushed into an in-order tag FIFO.
- Output side: each CORDIC result is routed back to the requester at the FIFO head; the CORDIC returns results in issue order.
- Sits between the requesting DSP blocks and the CORDIC; passive snoopers may still tap the CORDIC output stream.

Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- DATA_WIDTH, 64: tdata width on all streams.
- MAX_INFLIGHT, 16: tag FIFO depth = maximum outstanding CORDIC operations; power of 2.

Ports:
- s00_axis_aclk  in  1  single clock for all logic.
- s00_axis_aresetn  in  1  reset, asynchronous assert, active-low.
- s_req_tvalid  in  NUM_REQ  per-requester valid.
- s_req_tdata  in  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies slice i.
- s_req_tready  out  NUM_REQ  per-requester ready.
- m_cordic_tvalid  out  1  to CORDIC input.
- m_cordic_tdata  out  DATA_WIDTH  to CORDIC input.
- m_cordic_tready  in  1  from CORDIC input.
- s_cordic_tvalid  in  1  CORDIC result valid.
- s_cordic_tdata  in  DATA_WIDTH  CORDIC result: [31:0] magnitude, [63:32] angle.
- s_cordic_tready  out  1  backpressure to CORDIC output.
- m_res_tvalid  out  NUM_REQ  per-requester result valid.
- m_res_tdata  out  NUM_REQ*DATA_WIDTH  per-requester result data.
- m_res_tready  in  NUM_REQ  per-requester result ready.
- inflight  out  clog2(MAX_INFLIGHT)+1  outstanding operation count.
- orphan_err  out  1  sticky: a result arrived while the tag FIFO was empty.

Behaviour:
- Reset (async, aresetn=0):
  - rr_ptr=0; lock=0; FIFO pointers=0; inflight=0; orphan_err=0.
  - All tvalid/tready outputs are 0 while in reset.
- Arbitration:
  - Candidate = first i with s_req_tvalid[i], searching from rr_ptr upward with wrap.
  - Grant g = locked_g if lock=1, else the candidate.
- Input channel:
  - m_cordic_tvalid = (lock | any s_req_tvalid) & !fifo_full.
  - m_cordic_tdata = slice g.
  - s_req_tready[i] = (i==g) & m_cordic_tready & !fifo_full & m_cordic_tvalid.
  - Combinational path; zero added latency.
- AXI stability:
  - If m_cordic_tvalid=1 and m_cordic_tready=0: lock<=1, locked_g<=g. Grant and data are held until acceptance.
  - Requesters must not drop tvalid once asserted.
- On accept (m_cordic_tvalid & m_cordic_tready): push g into the tag FIFO; rr_ptr <= (g+1) mod NUM_REQ; lock<=0.
- Output routing:
  - h = FIFO head.
  - m_res_tvalid[i] = (i==h) & s_cordic_tvalid & !fifo_empty.
  - m_res_tdata: every slice carries s_cordic_tdata; only slice h is qualified by its valid.
  - s_cordic_tready = fifo_empty ? 1 : m_res_tready[h].
  - Pop on s_cordic_tvalid & s_cordic_tready & !fifo_empty.
- Orphan results:
  - s_cordic_tvalid while the FIFO is empty: beat is accepted and dropped; orphan_err<=1 (sticky until reset).
- Full/empty:
  - Push is blocked when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: inflight is unchanged.
- inflight = push count − pop count, registered. Range 0..MAX_INFLIGHT.
- Idle requester: if requester g is not valid and lock=0, the next candidate wins in the same cycle; no idle bubble.

Optional Feature:
- Macro: CORDIC_ARB_STATS_EN.
- Defined:
  - Adds output port grant_count, NUM_REQ*16 bits.
  - Per-requester 16-bit counter, incremented on each accepted beat from that requester.
  - Saturates at 0xFFFF; reset to 0.
- Undefined: port and counters are absent; no other behaviour change.

Test Plan:
- Requesters 0..3 all valid continuously, m_cordic_tready=1 → grants 0,1,2,3,0,1… one per cycle; each s_req_tready pulses once per 4 cycles.
- Req 2 valid, m_cordic_tready low 3 cycles, req 0 asserts in cycle 1 → m_cordic_tdata stays req 2 data, grant held until accept; req 0 granted next.
- Issue 16 ops with CORDIC output stalled → inflight=16, m_cordic_tvalid=0, all s_req_tready=0; release one result → inflight=15, the next issue proceeds.
- Issue order 1,3,1, results D0,D1,D2 → D0 on m_res 1, D1 on m_res 3, D2 on m_res 1; m_res_tready[3]=0 stalls s_cordic_tready.
- s_cordic_tvalid with the FIFO empty → beat dropped, orphan_err=1; persists until aresetn pulse.
- Assert aresetn=0 mid-stream with 5 inflight → immediate: inflight=0, all valids 0, rr_ptr=0; after release, req 0 wins first.

Source files
------------

// File: rtl/cordic_share_arbiter.sv
// Round-robin sharing of one AXI-Stream CORDIC core between NUM_REQ requesters,
// with in-order tag routing of results. Optional per-requester grant counters: CORDIC_ARB_STATS_EN.
module cordic_share_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned MAX_INFLIGHT = 16
) (
   input  logic                            s00_axis_aclk,
   input  logic                            s00_axis_aresetn,
   input  logic [NUM_REQ-1:0]              s_req_tvalid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_req_tdata,
   output logic [NUM_REQ-1:0]              s_req_tready,
   output logic                            m_cordic_tvalid,
   output logic [DATA_WIDTH-1:0]           m_cordic_tdata,
   input  logic                            m_cordic_tready,
   input  logic                            s_cordic_tvalid,
   input  logic [DATA_WIDTH-1:0]           s_cordic_tdata,
   output logic                            s_cordic_tready,
   output logic [NUM_REQ-1:0]              m_res_tvalid,
   output logic [NUM_REQ*DATA_WIDTH-1:0]   m_res_tdata,
   input  logic [NUM_REQ-1:0]              m_res_tready,
   output logic [$clog2(MAX_INFLIGHT):0]   inflight,
   output logic                            orphan_err
`ifdef CORDIC_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]           grant_count
`endif
);

   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned AW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] locked_g;
   logic            lock;
   logic [ID_W-1:0] cand;
   logic            found;
   int unsigned     scan_idx;
   logic [ID_W-1:0] g;
   logic [ID_W-1:0] next_rr;

   logic [ID_W-1:0] tag_mem [MAX_INFLIGHT];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [ID_W-1:0] head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;

   assign fifo_full  = (inflight == CNT_W'(MAX_INFLIGHT));
   assign fifo_empty = (inflight == '0);
   assign head       = tag_mem[rd_ptr];

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      cand     = '0;
      found    = 1'b0;
      scan_idx = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = (32'(rr_ptr) + k) % NUM_REQ;
         if (!found && s_req_tvalid[scan_idx]) begin
            cand  = ID_W'(scan_idx);
            found = 1'b1;
         end
      end
   end

   assign g       = lock ? locked_g : cand;
   assign next_rr = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + ID_W'(1);

   assign m_cordic_tvalid = s00_axis_aresetn & (lock | (|s_req_tvalid)) & ~fifo_full;
   assign m_cordic_tdata  = s_req_tdata[32'(g)*DATA_WIDTH +: DATA_WIDTH];
   assign push            = m_cordic_tvalid & m_cordic_tready;

   always_comb begin
      s_req_tready    = '0;
      s_req_tready[g] = push;
   end

   // Results go to the requester whose tag sits at the FIFO head; orphans are sunk.
   assign s_cordic_tready = s00_axis_aresetn & (fifo_empty | m_res_tready[head]);
   assign pop             = s_cordic_tvalid & s_cordic_tready & ~fifo_empty;
   assign m_res_tdata     = {NUM_REQ{s_cordic_tdata}};

   always_comb begin
      m_res_tvalid       = '0;
      m_res_tvalid[head] = s00_axis_aresetn & s_cordic_tvalid & ~fifo_empty;
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (push) tag_mem[wr_ptr] <= g;
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         rr_ptr     <= '0;
         lock       <= 1'b0;
         locked_g   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         inflight   <= '0;
         orphan_err <= 1'b0;
      end else begin
         if (push) begin
            rr_ptr <= next_rr;
            lock   <= 1'b0;
            wr_ptr <= wr_ptr + AW'(1);
         end else if (m_cordic_tvalid) begin
            lock     <= 1'b1;
            locked_g <= g;
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: inflight <= inflight;
         endcase
         if (s_cordic_tvalid && fifo_empty) orphan_err <= 1'b1;
      end
   end

`ifdef CORDIC_ARB_STATS_EN
   logic [15:0] gcnt [NUM_REQ];

   // Saturating count of accepted beats per requester.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) gcnt[i] <= '0;
      end else if (push && gcnt[g] != 16'hFFFF) begin
         gcnt[g] <= gcnt[g] + 16'd1;
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
      assign grant_count[i*16 +: 16] = gcnt[i];
   end
`endif

endmodule
